// File: rtl/am2940_dma_sequencer.sv
// Host-side programming sequencer for the AM2940 DMA address generator.
// Issues control/address/word-count setup, runs the counters until done, then reads back the address counter.
module am2940_dma_sequencer #(
    parameter int INSTR_LENGTH   = 3,
    parameter int DATA_LENGTH    = 8,
    parameter int TIMEOUT_CYCLES = 511
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    reinit,
    input  logic [2:0]              ctrl_in,
    input  logic [DATA_LENGTH-1:0]  addr_in,
    input  logic [DATA_LENGTH-1:0]  count_in,
    input  logic                    abort,
    input  logic                    done,
    input  logic [DATA_LENGTH-1:0]  data_in,
    output logic [INSTR_LENGTH-1:0] instruction,
    output logic [DATA_LENGTH-1:0]  data_out,
    output logic                    data_oe,
    output logic                    oena,
    output logic                    cinac,
    output logic                    cinwc,
    output logic                    busy,
    output logic                    finished,
    output logic                    error,
    output logic [DATA_LENGTH-1:0]  final_addr,
    output logic [DATA_LENGTH:0]    xfer_len
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int XW = DATA_LENGTH + 1;

    localparam logic [INSTR_LENGTH-1:0] I_WRC  = INSTR_LENGTH'(0);
    localparam logic [INSTR_LENGTH-1:0] I_IDLE = INSTR_LENGTH'(1);
    localparam logic [INSTR_LENGTH-1:0] I_RDAC = INSTR_LENGTH'(3);
    localparam logic [INSTR_LENGTH-1:0] I_REIN = INSTR_LENGTH'(4);
    localparam logic [INSTR_LENGTH-1:0] I_LDAC = INSTR_LENGTH'(5);
    localparam logic [INSTR_LENGTH-1:0] I_LDWC = INSTR_LENGTH'(6);
    localparam logic [INSTR_LENGTH-1:0] I_RUN  = INSTR_LENGTH'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CTRL,
        S_LD_ADDR,
        S_LD_WC,
        S_REINIT,
        S_RUN,
        S_RD_AC
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              ctrl_q, ctrl_d;
    logic [DATA_LENGTH-1:0]  addr_q, addr_d;
    logic [DATA_LENGTH-1:0]  count_q, count_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [INSTR_LENGTH-1:0] instruction_q, instruction_d;
    logic [DATA_LENGTH-1:0]  data_out_q, data_out_d;
    logic                    data_oe_q, data_oe_d;
    logic                    oena_q, oena_d;
    logic                    cinac_q, cinac_d;
    logic                    cinwc_q, cinwc_d;
    logic                    busy_q, busy_d;
    logic                    finished_q, finished_d;
    logic                    error_q, error_d;
    logic [DATA_LENGTH-1:0]  final_addr_q, final_addr_d;
    logic [XW-1:0]           xfer_len_q, xfer_len_d;

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        addr_d       = addr_q;
        count_d      = count_q;
        cnt_inc      = cnt_q + CW'(1);
        cnt_d        = cnt_q;
        final_addr_d = final_addr_q;
        xfer_len_d   = xfer_len_q;
        finished_d   = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ctrl_d  = ctrl_in;
                    addr_d  = addr_in;
                    count_d = count_in;
                    state_d = reinit ? S_REINIT : S_WR_CTRL;
                end
            end
            S_WR_CTRL: state_d = S_LD_ADDR;
            S_LD_ADDR: state_d = S_LD_WC;
            S_LD_WC:   state_d = S_RUN;
            S_REINIT:  state_d = S_RUN;
            S_RUN: begin
                cnt_d = cnt_inc;
                if (done) begin
                    xfer_len_d = XW'(cnt_inc);
                    state_d    = S_RD_AC;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end
            end
            S_RD_AC: begin
                final_addr_d = data_in;
                finished_d   = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other outcome, including a coincident done or readback.
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            error_d      = 1'b1;
            finished_d   = 1'b0;
            final_addr_d = final_addr_q;
            xfer_len_d   = xfer_len_q;
        end

        if (state_d == S_RUN && state_q != S_RUN) begin
            cnt_d = '0;
        end
    end

    // Pin values are decoded from the next state so every output is a flop.
    always_comb begin
        instruction_d = I_IDLE;
        data_out_d    = '0;
        data_oe_d     = 1'b0;
        oena_d        = 1'b1;
        cinac_d       = 1'b1;
        cinwc_d       = 1'b1;
        busy_d        = (state_d != S_IDLE);

        case (state_d)
            S_WR_CTRL: begin
                instruction_d = I_WRC;
                data_out_d    = DATA_LENGTH'(ctrl_d);
                data_oe_d     = 1'b1;
            end
            S_LD_ADDR: begin
                instruction_d = I_LDAC;
                data_out_d    = addr_d;
                data_oe_d     = 1'b1;
            end
            S_LD_WC: begin
                instruction_d = I_LDWC;
                data_out_d    = count_d;
                data_oe_d     = 1'b1;
            end
            S_REINIT: instruction_d = I_REIN;
            S_RUN: begin
                instruction_d = I_RUN;
                oena_d        = 1'b0;
                cinac_d       = 1'b0;
                cinwc_d       = 1'b0;
            end
            S_RD_AC: instruction_d = I_RDAC;
            default: instruction_d = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ctrl_q        <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            cnt_q         <= '0;
            instruction_q <= I_IDLE;
            data_out_q    <= '0;
            data_oe_q     <= 1'b0;
            oena_q        <= 1'b1;
            cinac_q       <= 1'b1;
            cinwc_q       <= 1'b1;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            error_q       <= 1'b0;
            final_addr_q  <= '0;
            xfer_len_q    <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            instruction_q <= instruction_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            oena_q        <= oena_d;
            cinac_q       <= cinac_d;
            cinwc_q       <= cinwc_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
            error_q       <= error_d;
            final_addr_q  <= final_addr_d;
            xfer_len_q    <= xfer_len_d;
        end
    end

    assign instruction = instruction_q;
    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;
    assign oena        = oena_q;
    assign cinac       = cinac_q;
    assign cinwc       = cinwc_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign error       = error_q;
    assign final_addr  = final_addr_q;
    assign xfer_len    = xfer_len_q;

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Directed bench for am2940_dma_sequencer: table of transfers plus abort, timeout and async-reset sequences.
module tb_am2940_dma_sequencer;

    localparam int TO = 511;

    logic       clk, rst, start, reinit, abort, done;
    logic [2:0] ctrl_in;
    logic [7:0] addr_in, count_in, data_in;
    logic [2:0] instruction;
    logic [7:0] data_out, final_addr;
    logic       data_oe, oena, cinac, cinwc, busy, finished, error;
    logic [8:0] xfer_len;

    int total = 0;
    int bad   = 0;

    am2940_dma_sequencer #(
        .INSTR_LENGTH   (3),
        .DATA_LENGTH    (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reinit      (reinit),
        .ctrl_in     (ctrl_in),
        .addr_in     (addr_in),
        .count_in    (count_in),
        .abort       (abort),
        .done        (done),
        .data_in     (data_in),
        .instruction (instruction),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .oena        (oena),
        .cinac       (cinac),
        .cinwc       (cinwc),
        .busy        (busy),
        .finished    (finished),
        .error       (error),
        .final_addr  (final_addr),
        .xfer_len    (xfer_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       reinit;
        logic [2:0] ctrl;
        logic [7:0] addr;
        logic [7:0] count;
        int         done_at;
        logic [7:0] fin;
        int         xlen;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input vec_t v);
        start = 1'b1; reinit = v.reinit;
        ctrl_in = v.ctrl; addr_in = v.addr; count_in = v.count;
        tick();
        start = 1'b0; reinit = 1'b0;
        if (!v.reinit) begin
            chk("wrc_instr", 32'(instruction), 32'd0);
            chk("wrc_data",  32'(data_out), 32'(v.ctrl));
            chk("wrc_oe",    32'(data_oe), 32'd1);
            chk("wrc_busy",  32'(busy), 32'd1);
            tick();
            chk("lda_instr", 32'(instruction), 32'd5);
            chk("lda_data",  32'(data_out), 32'(v.addr));
            chk("lda_oe",    32'(data_oe), 32'd1);
            tick();
            chk("ldwc_instr", 32'(instruction), 32'd6);
            chk("ldwc_data",  32'(data_out), 32'(v.count));
            chk("ldwc_oe",    32'(data_oe), 32'd1);
        end else begin
            chk("rein_instr", 32'(instruction), 32'd4);
            chk("rein_oe",    32'(data_oe), 32'd0);
            chk("rein_busy",  32'(busy), 32'd1);
        end
        tick();
        for (int k = 1; k <= v.done_at; k++) begin
            chk("run_instr", 32'(instruction), 32'd7);
            chk("run_pins",  32'({oena, cinac, cinwc, data_oe}), 32'h0);
            if (k == v.done_at) done = 1'b1;
            tick();
            done = 1'b0;
        end
        chk("rdac_instr", 32'(instruction), 32'd3);
        chk("rdac_pins",  32'({oena, cinac, cinwc, data_oe}), 32'hE);
        chk("rdac_busy",  32'(busy), 32'd1);
        data_in = v.fin;
        tick();
        data_in = '0;
        chk("fin_pulse", 32'(finished), 32'd1);
        chk("fin_busy",  32'(busy), 32'd0);
        chk("fin_instr", 32'(instruction), 32'd1);
        chk("fin_addr",  32'(final_addr), 32'(v.fin));
        chk("fin_xlen",  32'(xfer_len), 32'(v.xlen));
        tick();
        chk("fin_pulse_end", 32'(finished), 32'd0);
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b0, 3'd0, 8'd15,   8'd9,  9,   8'd24,   9};
        tbl[1] = '{1'b1, 3'd0, 8'd15,   8'd9,  9,   8'd24,   9};
        tbl[2] = '{1'b0, 3'd2, 8'hFE,   8'd2,  2,   8'h00,   2};
        tbl[3] = '{1'b0, 3'd1, 8'h80,   8'd0,  1,   8'h81,   1};
        tbl[4] = '{1'b0, 3'd3, 8'h10,   8'd0,  256, 8'h10,   256};

        rst = 1'b1; start = 0; reinit = 0; abort = 0; done = 0;
        ctrl_in = '0; addr_in = '0; count_in = '0; data_in = '0;
        tick(); tick();
        chk("rst_instr", 32'(instruction), 32'd1);
        chk("rst_pins",  32'({data_oe, oena, cinac, cinwc, busy, finished, error}), 32'b0111000);
        chk("rst_regs",  32'({data_out, final_addr, xfer_len}), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_instr", 32'(instruction), 32'd1);
        chk("idle_busy",  32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) run_xfer(tbl[i]);

        // Abort with a coincident done; a start mid-RUN is ignored.
        start = 1'b1; ctrl_in = 3'd7; addr_in = 8'd7; count_in = 8'hF0;
        tick(); start = 1'b0;
        chk("ab_wrc_data", 32'(data_out), 32'd7);
        tick(); tick(); tick();
        for (int k = 1; k <= 5; k++) begin
            chk("ab_run_instr", 32'(instruction), 32'd7);
            if (k == 2) start = 1'b1;
            if (k == 5) begin abort = 1'b1; done = 1'b1; end
            tick();
            start = 1'b0; abort = 1'b0; done = 1'b0;
        end
        chk("ab_error", 32'(error), 32'd1);
        chk("ab_busy",  32'(busy), 32'd0);
        chk("ab_pins",  32'({instruction, oena, cinac, cinwc, finished}), 32'b001_1110);
        chk("ab_faddr", 32'(final_addr), 32'h10);
        chk("ab_xlen",  32'(xfer_len), 32'd256);
        tick();
        chk("ab_error_end", 32'(error), 32'd0);
        chk("ab_no_relaunch", 32'(busy), 32'd0);

        // Timeout with done held low, via the reinit path.
        start = 1'b1; reinit = 1'b1;
        tick(); start = 1'b0; reinit = 1'b0;
        tick();
        n = 0;
        while (instruction == 3'd7 && n < TO + 10) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 32'(TO));
        chk("to_error",  32'(error), 32'd1);
        chk("to_oena",   32'(oena), 32'd1);
        chk("to_busy",   32'(busy), 32'd0);
        chk("to_xlen",   32'(xfer_len), 32'd256);
        tick();
        chk("to_error_end", 32'(error), 32'd0);

        // Asynchronous reset in LD_WC.
        start = 1'b1; ctrl_in = 3'd0; addr_in = 8'd15; count_in = 8'd9;
        tick(); start = 1'b0;
        tick(); tick();
        chk("ar_ldwc_oe", 32'(data_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_oe",    32'(data_oe), 32'd0);
        chk("ar_instr", 32'(instruction), 32'd1);
        chk("ar_busy",  32'(busy), 32'd0);
        chk("ar_regs",  32'({final_addr, xfer_len}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        run_xfer(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
